// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: emits cfg_num_pkts packets of cfg_beats beats, separated by cfg_gap idle cycles.
// Optional AXIS_PKT_GEN_SEQ_EN overwrites beat-0 tdata[31:0] with the running packet count.
module axis_pkt_gen #(
    parameter int C_M_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int BEAT_WIDTH           = 8,
    parameter int GAP_WIDTH            = 8
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic                              start,
    input  logic                              stop,
    input  logic [31:0]                       cfg_num_pkts,
    input  logic [BEAT_WIDTH-1:0]             cfg_beats,
    input  logic [GAP_WIDTH-1:0]              cfg_gap,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    cfg_hdr_data,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    cfg_body_data,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  cfg_last_keep,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   cfg_tuser,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic                              busy,
    output logic                              done,
    output logic [31:0]                       pkt_cnt
);
    localparam int KW = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t                            state_q, state_d;
    logic [BEAT_WIDTH-1:0]             beat_q, beat_d;
    logic [GAP_WIDTH-1:0]              gap_q, gap_d;
    logic [31:0]                       cnt_q, cnt_d;
    logic                              stop_q, stop_d;
    logic                              load;

    logic [31:0]                       num_q;
    logic [BEAT_WIDTH-1:0]             beats_q;
    logic [GAP_WIDTH-1:0]              gapcfg_q;
    logic [C_M_AXIS_DATA_WIDTH-1:0]    hdr_q, body_q;
    logic [KW-1:0]                     keep_q;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_q;

    logic                              is_last;
    assign is_last = (beat_q == beats_q - BEAT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    beat_d  = '0;
                    gap_d   = '0;
                    stop_d  = 1'b0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (stop) stop_d = 1'b1;
                if (m_axis_tready) begin
                    if (is_last) begin
                        beat_d = '0;
                        cnt_d  = cnt_q + 32'd1;
                        // Stop seen this very cycle counts as pending too.
                        if ((num_q != 32'd0 && cnt_q + 32'd1 == num_q) || stop_q || stop)
                            state_d = DONE;
                        else if (gapcfg_q != '0) begin
                            state_d = GAP;
                            gap_d   = gapcfg_q;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                if (stop || stop_q) begin
                    stop_d  = 1'b1;
                    state_d = DONE;
                end else if (gap_q <= GAP_WIDTH'(1)) begin
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - GAP_WIDTH'(1);
                end
            end
            DONE: begin
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            num_q    <= '0;
            beats_q  <= BEAT_WIDTH'(1);
            gapcfg_q <= '0;
            hdr_q    <= '0;
            body_q   <= '0;
            keep_q   <= '0;
            tuser_q  <= '0;
        end else if (load) begin
            num_q    <= cfg_num_pkts;
            beats_q  <= (cfg_beats == '0) ? BEAT_WIDTH'(1) : cfg_beats;
            gapcfg_q <= cfg_gap;
            hdr_q    <= cfg_hdr_data;
            body_q   <= cfg_body_data;
            keep_q   <= cfg_last_keep;
            tuser_q  <= cfg_tuser;
        end
    end

    // Beat fields decode from registered state only, so they hold steady under backpressure.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        if (state_q == SEND) begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = is_last;
            m_axis_tkeep  = is_last ? keep_q : {KW{1'b1}};
            if (beat_q == '0) begin
                m_axis_tdata = hdr_q;
`ifdef AXIS_PKT_GEN_SEQ_EN
                m_axis_tdata[31:0] = cnt_q;
`endif
                m_axis_tuser = tuser_q;
            end else begin
                m_axis_tdata = body_q;
            end
        end
    end

    assign busy    = (state_q == SEND) || (state_q == GAP);
    assign done    = (state_q == DONE);
    assign pkt_cnt = cnt_q;

endmodule
